// File: rtl/z80_bus_target_pkg.sv
// rtl/z80_bus_target_pkg.sv - shared state encoding and constants for the Z80 bus target
package z80_bus_target_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int         DEFAULT_TIMEOUT = 255;
    localparam logic [7:0] OPEN_BUS        = 8'hFF;

    // I/O cycles only carry a meaningful port number on a[7:0]
    function automatic logic [15:0] effective_mask(input logic io_space, input logic [15:0] mask);
        return io_space ? {8'h00, mask[7:0]} : mask;
    endfunction

endpackage

// File: rtl/z80_addr_decode.sv
// rtl/z80_addr_decode.sv - address window decode and IM2 acknowledge detect for Z80 bus slaves
module z80_addr_decode
    import z80_bus_target_pkg::*;
#(
    parameter bit          IO_SPACE  = 1'b0,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] ADDR_MASK = 16'hF000
) (
    input  logic [15:0] a,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    output logic        hit,
    output logic        intack
);

    localparam logic [15:0] MASK = effective_mask(IO_SPACE, ADDR_MASK);

    logic space;
    logic strobe;
    logic match;

    // A hit needs the right address space, a data strobe and an in-window address;
    // an interrupt acknowledge (m1 with iorq) is excluded from I/O space
    always_comb begin
        space  = IO_SPACE ? (~iorq_n & m1_n) : ~mreq_n;
        strobe = ~rd_n | ~wr_n;
        match  = ((a & MASK) == (BASE_ADDR & MASK));
        hit    = space & strobe & match;
        intack = ~m1_n & ~iorq_n;
    end

endmodule

// File: rtl/z80_bus_target.sv
// rtl/z80_bus_target.sv - Z80 bus responder converting window hits into req/ack transactions
module z80_bus_target
    import z80_bus_target_pkg::*;
#(
    parameter bit          IO_SPACE  = 1'b0,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] ADDR_MASK = 16'hF000,
    parameter int          TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    output logic        wait_n,
    output logic        int_n,
    output logic        req,
    output logic        req_we,
    output logic [15:0] req_addr,
    output logic [7:0]  req_wdata,
    input  logic        ack,
    input  logic [7:0]  rdata,
    input  logic        int_req,
    input  logic [7:0]  int_vector,
    output logic        int_ack,
    output logic        timeout_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic hit;
    logic intack;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        req_we_q, req_we_d;
    logic [15:0] req_addr_q, req_addr_d;
    logic [7:0]  req_wdata_q, req_wdata_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        int_n_q, int_n_d;
    logic        int_ack_q, int_ack_d;
    logic        timeout_err_q, timeout_err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        intack_prev_q, intack_prev_d;
    logic        aborted_q, aborted_d;

    z80_addr_decode #(
        .IO_SPACE  (IO_SPACE),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_MASK (ADDR_MASK)
    ) u_decode (
        .a      (a),
        .mreq_n (mreq_n),
        .iorq_n (iorq_n),
        .rd_n   (rd_n),
        .wr_n   (wr_n),
        .m1_n   (m1_n),
        .hit    (hit),
        .intack (intack)
    );

    // Next-state logic: IDLE preloads the vector, ACCESS waits for ack or timeout,
    // DONE releases wait until the CPU drops its strobe
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        req_we_d      = req_we_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        d_out_d       = d_out_q;
        cnt_d         = cnt_q;
        aborted_d     = aborted_q;
        timeout_err_d = 1'b0;
        int_n_d       = ~int_req;
        intack_prev_d = intack;
        int_ack_d     = intack & ~intack_prev_q;

        case (state_q)
            ST_IDLE: begin
                d_out_d   = int_vector;
                aborted_d = 1'b0;
                if (hit) begin
                    req_d       = 1'b1;
                    req_we_d    = ~wr_n;
                    req_addr_d  = a;
                    req_wdata_d = d_in;
                    cnt_d       = 8'd0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // once the CPU walks away, finish the internal side and skip DONE
                if (!hit) aborted_d = 1'b1;
                if (ack) begin
                    req_d = 1'b0;
                    if (!req_we_q) d_out_d = rdata;
                    state_d = (aborted_q || !hit) ? ST_IDLE : ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d         = 1'b0;
                    d_out_d       = OPEN_BUS;
                    timeout_err_d = 1'b1;
                    state_d       = (aborted_q || !hit) ? ST_IDLE : ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (!hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            req_we_q      <= 1'b0;
            req_addr_q    <= 16'h0000;
            req_wdata_q   <= 8'h00;
            d_out_q       <= 8'h00;
            int_n_q       <= 1'b1;
            int_ack_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= 8'd0;
            intack_prev_q <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            req_we_q      <= req_we_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            d_out_q       <= d_out_d;
            int_n_q       <= int_n_d;
            int_ack_q     <= int_ack_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
            intack_prev_q <= intack_prev_d;
            aborted_q     <= aborted_d;
        end
    end

    // wait_n must react within the first strobe cycle, so it stays combinational
    assign wait_n      = ~(hit & (state_q != ST_DONE));
    assign d_oe        = (hit & ~rd_n & (state_q == ST_DONE)) | intack;
    assign d_out       = d_out_q;
    assign int_n       = int_n_q;
    assign req         = req_q;
    assign req_we      = req_we_q;
    assign req_addr    = req_addr_q;
    assign req_wdata   = req_wdata_q;
    assign int_ack     = int_ack_q;
    assign timeout_err = timeout_err_q;

endmodule
